// File: rtl/hwpe_sel_ctrl.sv
// hwpe_sel_ctrl: sequences changes of the HWPE subsystem select/enable so that
// the live selection is only rewritten once the config bus is blocked, the
// active HWPE is idle, all outstanding TCDM/config-bus traffic has drained and
// the subsystem enable (clock gate) has been dropped.
// Optional build macro: HWPE_SEL_CTRL_TIMEOUT_EN bounds DRAIN to DRAIN_TIMEOUT
// cycles, then forces the switch and flags err_o[1].
module hwpe_sel_ctrl #(
  parameter int unsigned MAX_NUM_HWPES = 4,
  parameter int unsigned N_HWPES       = 2,
  parameter int unsigned OUTST_W       = 4,
  parameter int unsigned WAKE_CYCLES   = 2,
  parameter int unsigned DRAIN_TIMEOUT = 1024,
  localparam int unsigned SEL_W        = $clog2(MAX_NUM_HWPES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [SEL_W-1:0] cfg_sel_i,
  input  logic             cfg_en_i,
  input  logic             hwpe_busy_i,
  input  logic             tcdm_req_i,
  input  logic             tcdm_gnt_i,
  input  logic             tcdm_r_valid_i,
  input  logic             periph_req_i,
  input  logic             periph_gnt_i,
  input  logic             periph_r_valid_i,
  output logic             periph_block_o,
  output logic             hwpe_en_o,
  output logic [SEL_W-1:0] hwpe_sel_o,
  output logic             switching_o,
  output logic [1:0]       err_o,
  input  logic             err_clr_i
);

  localparam int unsigned WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_OFF,
    S_SWITCH,
    S_WAKE
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   tgt_sel_q;
  logic               tgt_en_q;
  logic [WAKE_W-1:0]  wake_cnt_q;
  logic [OUTST_W-1:0] tcdm_cnt_q, periph_cnt_q;
  logic               accept, illegal, noop, drained, drain_timeout;

  // Saturating outstanding-transaction count: issue and response in the same
  // cycle cancel out.
  function automatic logic [OUTST_W-1:0] outst_next(input logic [OUTST_W-1:0] cnt,
                                                    input logic inc,
                                                    input logic dec);
    logic [OUTST_W-1:0] res;
    res = cnt;
    if (inc && !dec && (cnt != '1)) begin
      res = cnt + 1'b1;
    end else if (dec && !inc && (cnt != '0)) begin
      res = cnt - 1'b1;
    end
    return res;
  endfunction

  assign accept  = cfg_valid_i && cfg_ready_o;
  assign illegal = (32'(cfg_sel_i) >= N_HWPES);
  assign noop    = (cfg_sel_i == hwpe_sel_o) && (cfg_en_i == hwpe_en_o);
  assign drained = !hwpe_busy_i && (tcdm_cnt_q == '0) && (periph_cnt_q == '0);

`ifdef HWPE_SEL_CTRL_TIMEOUT_EN
  localparam int unsigned TO_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DRAIN_TIMEOUT - 1);

  logic [TO_W-1:0] drain_cnt_q;

  // Cycles spent in DRAIN, restarting from zero on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt_q <= '0;
    end else if (state_q == S_DRAIN) begin
      drain_cnt_q <= drain_cnt_q + 1'b1;
    end else begin
      drain_cnt_q <= '0;
    end
  end

  assign drain_timeout = (state_q == S_DRAIN) && !drained && (drain_cnt_q == TO_LAST);
`else
  assign drain_timeout = 1'b0;
`endif

  // Next-state decode of the switch sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && !illegal && !noop) begin
          state_d = (!hwpe_en_o && cfg_en_i) ? S_SWITCH : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drained || drain_timeout) begin
          state_d = S_OFF;
        end
      end
      S_OFF: begin
        state_d = (!tgt_en_q && (tgt_sel_q == hwpe_sel_o)) ? S_IDLE : S_SWITCH;
      end
      S_SWITCH: begin
        state_d = tgt_en_q ? S_WAKE : S_IDLE;
      end
      S_WAKE: begin
        if (wake_cnt_q == '0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register, request latch and registered outputs. Each output is the
  // registered action of the state just left, so en/sel/block trail the state
  // by one cycle; ready drops on the accepting edge to avoid a second accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      tgt_sel_q      <= '0;
      tgt_en_q       <= 1'b0;
      wake_cnt_q     <= '0;
      cfg_ready_o    <= 1'b1;
      periph_block_o <= 1'b0;
      switching_o    <= 1'b0;
      hwpe_en_o      <= 1'b0;
      hwpe_sel_o     <= '0;
    end else begin
      state_q        <= state_d;
      cfg_ready_o    <= (state_q == S_IDLE) && (state_d == S_IDLE);
      periph_block_o <= (state_q != S_IDLE);
      switching_o    <= (state_q != S_IDLE);
      if ((state_q == S_IDLE) && (state_d != S_IDLE)) begin
        tgt_sel_q <= cfg_sel_i;
        tgt_en_q  <= cfg_en_i;
      end
      if (state_q == S_OFF) begin
        hwpe_en_o <= 1'b0;
      end else if (state_q == S_WAKE) begin
        hwpe_en_o <= 1'b1;
      end
      if (state_q == S_SWITCH) begin
        hwpe_sel_o <= tgt_sel_q;
        wake_cnt_q <= WAKE_LAST;
      end else if ((state_q == S_WAKE) && (wake_cnt_q != '0)) begin
        wake_cnt_q <= wake_cnt_q - 1'b1;
      end
    end
  end

  // Sticky error flags; a clear wins over a set in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_o <= '0;
    end else if (err_clr_i) begin
      err_o <= '0;
    end else begin
      if ((state_q == S_IDLE) && accept && illegal) begin
        err_o[0] <= 1'b1;
      end
      if (drain_timeout) begin
        err_o[1] <= 1'b1;
      end
    end
  end

  // Outstanding-transaction monitors; a forced drain exit discards them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcdm_cnt_q   <= '0;
      periph_cnt_q <= '0;
    end else if (drain_timeout) begin
      tcdm_cnt_q   <= '0;
      periph_cnt_q <= '0;
    end else begin
      tcdm_cnt_q   <= outst_next(tcdm_cnt_q, tcdm_req_i && tcdm_gnt_i, tcdm_r_valid_i);
      periph_cnt_q <= outst_next(periph_cnt_q, periph_req_i && periph_gnt_i, periph_r_valid_i);
    end
  end

endmodule

// File: tb/tb_hwpe_sel_ctrl.sv
// Directed bench for hwpe_sel_ctrl: expected final selection/enable/error per
// request is queued when the request is driven and checked when the block
// returns to idle; cycle-exact checks cover the sequence timing.
module tb_hwpe_sel_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid_i = 1'b0;
  logic       cfg_ready_o;
  logic [1:0] cfg_sel_i = '0;
  logic       cfg_en_i = 1'b0;
  logic       hwpe_busy_i = 1'b0;
  logic       tcdm_req_i = 1'b0, tcdm_gnt_i = 1'b0, tcdm_r_valid_i = 1'b0;
  logic       periph_req_i = 1'b0, periph_gnt_i = 1'b0, periph_r_valid_i = 1'b0;
  logic       periph_block_o, hwpe_en_o, switching_o;
  logic [1:0] hwpe_sel_o;
  logic [1:0] err_o;
  logic       err_clr_i = 1'b0;

  hwpe_sel_ctrl #(
    .MAX_NUM_HWPES(4),
    .N_HWPES(2),
    .OUTST_W(4),
    .WAKE_CYCLES(2),
    .DRAIN_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_sel_i(cfg_sel_i), .cfg_en_i(cfg_en_i),
    .hwpe_busy_i(hwpe_busy_i),
    .tcdm_req_i(tcdm_req_i), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_r_valid_i(tcdm_r_valid_i),
    .periph_req_i(periph_req_i), .periph_gnt_i(periph_gnt_i), .periph_r_valid_i(periph_r_valid_i),
    .periph_block_o(periph_block_o), .hwpe_en_o(hwpe_en_o), .hwpe_sel_o(hwpe_sel_o),
    .switching_o(switching_o), .err_o(err_o), .err_clr_i(err_clr_i)
  );

  always #5 clk = ~clk;

`ifdef HWPE_SEL_CTRL_TIMEOUT_EN
  localparam int BUSY_HOLD = 10;
`else
  localparam int BUSY_HOLD = 20;
`endif

  typedef struct packed {
    logic [1:0] sel;
    logic       en;
    logic [1:0] err;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [1:0]  m_sel = '0;
  logic        m_en  = 1'b0;
  logic [1:0]  m_err = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle request; the model result is queued at drive time.
  task automatic request(input logic [1:0] sel, input logic en, input logic clr);
    exp_t e;
    cfg_sel_i   = sel;
    cfg_en_i    = en;
    cfg_valid_i = 1'b1;
    err_clr_i   = clr;
    if (clr) m_err = '0;
    if (sel >= 2'd2) begin
      if (!clr) m_err[0] = 1'b1;
    end else begin
      m_sel = sel;
      m_en  = en;
    end
    e = '{sel: m_sel, en: m_en, err: m_err};
    sb_q.push_back(e);
    tick();
    cfg_valid_i = 1'b0;
    err_clr_i   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    for (int i = 0; i < 200; i++) begin
      if (cfg_ready_o && !switching_o) break;
      tick();
    end
    chk({tag, "_done"}, {30'd0, cfg_ready_o, switching_o}, 32'h2);
    e = sb_q.pop_front();
    chk({tag, "_sel"}, {30'd0, hwpe_sel_o}, {30'd0, e.sel});
    chk({tag, "_en"}, {31'd0, hwpe_en_o}, {31'd0, e.en});
    chk({tag, "_err"}, {30'd0, err_o}, {30'd0, e.err});
    chk({tag, "_block"}, {31'd0, periph_block_o}, 32'h0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_en"}, {31'd0, hwpe_en_o}, 32'h0);
    chk({tag, "_sel"}, {30'd0, hwpe_sel_o}, 32'h0);
    chk({tag, "_block"}, {31'd0, periph_block_o}, 32'h0);
    chk({tag, "_switching"}, {31'd0, switching_o}, 32'h0);
    chk({tag, "_err"}, {30'd0, err_o}, 32'h0);
    chk({tag, "_ready"}, {31'd0, cfg_ready_o}, 32'h1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    tick();
    tick();
    chk_reset_vals("in_reset");
    rst_n = 1'b1;
    tick();
    chk_reset_vals("after_reset");

    // Enable sel=1 from disabled: no DRAIN, sel at t+2, en at t+3, ready at t+5
    request(2'd1, 1'b1, 1'b0);
    chk("t1_ready_t1", {31'd0, cfg_ready_o}, 32'h0);
    chk("t1_sel_t1", {30'd0, hwpe_sel_o}, 32'h0);
    tick();
    chk("t1_sel_t2", {30'd0, hwpe_sel_o}, 32'h1);
    chk("t1_en_t2", {31'd0, hwpe_en_o}, 32'h0);
    chk("t1_block_t2", {31'd0, periph_block_o}, 32'h1);
    tick();
    chk("t1_en_t3", {31'd0, hwpe_en_o}, 32'h1);
    tick();
    chk("t1_ready_t4", {31'd0, cfg_ready_o}, 32'h0);
    tick();
    chk("t1_ready_t5", {31'd0, cfg_ready_o}, 32'h1);
    wait_done("t1");

    // Move to sel=0, then three outstanding TCDM transactions gate a switch
    request(2'd0, 1'b1, 1'b0);
    wait_done("t2a");
    tcdm_req_i = 1'b1;
    tcdm_gnt_i = 1'b1;
    tick(); tick(); tick();
    tcdm_req_i = 1'b0;
    tcdm_gnt_i = 1'b0;
    request(2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t2_hold_block", {31'd0, periph_block_o}, 32'h1);
      chk("t2_hold_en", {31'd0, hwpe_en_o}, 32'h1);
      chk("t2_hold_sel", {30'd0, hwpe_sel_o}, 32'h0);
    end
    for (int k = 0; k < 3; k++) begin
      tcdm_r_valid_i = 1'b1;
      tick();
      tcdm_r_valid_i = 1'b0;
      if (k < 2) begin
        tick();
        tick();
        chk("t2_partial_en", {31'd0, hwpe_en_o}, 32'h1);
        chk("t2_partial_block", {31'd0, periph_block_o}, 32'h1);
      end
    end
    chk("t2_c1_en", {31'd0, hwpe_en_o}, 32'h1);
    tick();
    chk("t2_c2_en", {31'd0, hwpe_en_o}, 32'h1);
    tick();
    chk("t2_c3_en", {31'd0, hwpe_en_o}, 32'h0);
    chk("t2_c3_sel", {30'd0, hwpe_sel_o}, 32'h0);
    tick();
    chk("t2_c4_sel", {30'd0, hwpe_sel_o}, 32'h1);
    chk("t2_c4_en", {31'd0, hwpe_en_o}, 32'h0);
    tick();
    chk("t2_c5_en", {31'd0, hwpe_en_o}, 32'h1);
    wait_done("t2b");

    // Busy HWPE holds DRAIN; selection untouched meanwhile
    hwpe_busy_i = 1'b1;
    request(2'd0, 1'b1, 1'b0);
    for (int i = 0; i < BUSY_HOLD; i++) begin
      tick();
      chk("t3_busy_sel", {30'd0, hwpe_sel_o}, 32'h1);
      chk("t3_busy_en", {31'd0, hwpe_en_o}, 32'h1);
      chk("t3_busy_switching", {31'd0, switching_o}, 32'h1);
    end
    hwpe_busy_i = 1'b0;
    wait_done("t3");

    // Illegal selects, clear priority, no-op
    request(2'd3, 1'b1, 1'b0);
    chk("t4_err_t1", {30'd0, err_o}, 32'h1);
    chk("t4_ready_t1", {31'd0, cfg_ready_o}, 32'h1);
    tick();
    chk("t4_ready_t2", {31'd0, cfg_ready_o}, 32'h1);
    chk("t4_switching_t2", {31'd0, switching_o}, 32'h0);
    wait_done("t4a");
    request(2'd3, 1'b0, 1'b1);
    chk("t4_clr_prio", {30'd0, err_o}, 32'h0);
    wait_done("t4b");
    request(2'd2, 1'b0, 1'b0);
    wait_done("t4c");
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    m_err = '0;
    chk("t4_err_clr", {30'd0, err_o}, 32'h0);
    request(2'd0, 1'b1, 1'b0);
    chk("noop_ready", {31'd0, cfg_ready_o}, 32'h1);
    tick();
    chk("noop_switching", {31'd0, switching_o}, 32'h0);
    wait_done("noop");

    // TCDM counter: simultaneous inc/dec holds at 1; r_valid at 0 holds 0
    tcdm_req_i = 1'b1; tcdm_gnt_i = 1'b1;
    tick();
    tcdm_r_valid_i = 1'b1;
    tick();
    tcdm_req_i = 1'b0; tcdm_gnt_i = 1'b0; tcdm_r_valid_i = 1'b0;
    request(2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_one_left_en", {31'd0, hwpe_en_o}, 32'h1);
    end
    tcdm_r_valid_i = 1'b1;
    tick();
    tcdm_r_valid_i = 1'b0;
    wait_done("t5a");
    tcdm_r_valid_i = 1'b1;
    tick();
    tick();
    tcdm_r_valid_i = 1'b0;
    request(2'd0, 1'b1, 1'b0);
    tick();
    chk("t5_zero_t2_en", {31'd0, hwpe_en_o}, 32'h1);
    tick();
    chk("t5_zero_t3_en", {31'd0, hwpe_en_o}, 32'h0);
    wait_done("t5b");

    // Periph counter saturates at 15: 17 issues, 14 responses leave one pending
    periph_req_i = 1'b1; periph_gnt_i = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    periph_req_i = 1'b0; periph_gnt_i = 1'b0;
    request(2'd1, 1'b1, 1'b0);
    periph_r_valid_i = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    periph_r_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_sat_en", {31'd0, hwpe_en_o}, 32'h1);
    chk("t5_sat_switching", {31'd0, switching_o}, 32'h1);
    periph_r_valid_i = 1'b1;
    tick();
    periph_r_valid_i = 1'b0;
    wait_done("t5c");

`ifdef HWPE_SEL_CTRL_TIMEOUT_EN
    // Forced exit after 16 DRAIN cycles; counters discarded
    tcdm_req_i = 1'b1; tcdm_gnt_i = 1'b1;
    tick(); tick();
    tcdm_req_i = 1'b0; tcdm_gnt_i = 1'b0;
    hwpe_busy_i = 1'b1;
    m_err[1] = 1'b1;
    request(2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    chk("t6_err_t16", {30'd0, err_o}, 32'h0);
    chk("t6_en_t16", {31'd0, hwpe_en_o}, 32'h1);
    tick();
    chk("t6_err_t17", {30'd0, err_o}, 32'h2);
    wait_done("t6a");
    hwpe_busy_i = 1'b0;
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    m_err = '0;
    request(2'd1, 1'b1, 1'b0);
    tick();
    tick();
    chk("t6_cnt_cleared_en", {31'd0, hwpe_en_o}, 32'h0);
    wait_done("t6b");
`endif

    // Reset asserted during WAKE returns everything to reset values
    request(2'd0, 1'b0, 1'b0);
    wait_done("t7a");
    request(2'd1, 1'b1, 1'b0);
    tick();
    tick();
    chk("t7_in_wake_en", {31'd0, hwpe_en_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t7_async_reset");
    sb_q.delete();
    m_sel = '0;
    m_en  = 1'b0;
    m_err = '0;
    tick();
    rst_n = 1'b1;
    tick();
    chk_reset_vals("t7_after_reset");
    request(2'd1, 1'b1, 1'b0);
    wait_done("t7b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
